// File: rtl/extern_reg_pkg.sv
// Shared types and default configuration for the multi-channel register extern.
package extern_reg_pkg;

  localparam int CFG_NUM_CH = 2;
  localparam int CFG_DEPTH  = 1024;
  localparam int CFG_IDX_W  = 16;
  localparam int CFG_DATA_W = 8;
  localparam int PTR_W      = $clog2(CFG_DEPTH);

  typedef struct packed {
    logic [CFG_IDX_W-1:0]  index;
    logic                  update;
    logic [CFG_DATA_W-1:0] data;
  } req_t;

  typedef struct packed {
    logic [CFG_DATA_W-1:0] data;
  } resp_t;

  typedef enum logic {
    SWEEP = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/extern_reg_wr_arb.sv
// Same-cycle write conflict resolution: on a shared address the lowest channel wins.
module extern_reg_wr_arb #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 10
) (
  input  logic [NUM_CH-1:0]        wr_req,
  input  logic [NUM_CH*ADDR_W-1:0] wr_addr,
  output logic [NUM_CH-1:0]        wr_en
);

  always_comb begin
    wr_en = wr_req;
    for (int c = 1; c < NUM_CH; c++) begin
      for (int j = 0; j < c; j++) begin
        if (wr_req[j] && wr_req[c] &&
            (wr_addr[j*ADDR_W +: ADDR_W] == wr_addr[c*ADDR_W +: ADDR_W])) begin
          wr_en[c] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/extern_reg_array.sv
// NUM_CH-channel register extern over one shared array, with clear sweep,
// write arbitration and out-of-range detection; fixed one-cycle response.
module extern_reg_array
  import extern_reg_pkg::*;
#(
  parameter int               NUM_CH    = CFG_NUM_CH,
  parameter int               DEPTH     = CFG_DEPTH,
  parameter int               IDX_W     = CFG_IDX_W,
  parameter int               DATA_W    = CFG_DATA_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_CH-1:0]          req_valid,
  input  logic [NUM_CH*IDX_W-1:0]    req_bits_index,
  input  logic [NUM_CH-1:0]          req_bits_update,
  input  logic [NUM_CH*DATA_W-1:0]   req_bits_data,
  output logic [NUM_CH-1:0]          resp_valid,
  output logic [NUM_CH*DATA_W-1:0]   resp_bits_data,
  input  logic                       clear,
  output logic                       init_done,
  output logic                       oob_err,
  output logic [15:0]                init_drop_cnt
);

  localparam int          ADDR_W  = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {14'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                init_done_q, init_done_d;
  logic                sweep_we;
  logic                busy;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [IDX_W-1:0]    idx     [NUM_CH];
  logic [ADDR_W-1:0]   addr    [NUM_CH];
  logic [DATA_W-1:0]   wr_data [NUM_CH];
  logic [NUM_CH-1:0]   oob;
  logic [NUM_CH-1:0]   wr_req, wr_en;
  logic [NUM_CH*ADDR_W-1:0] wr_addr_flat;

  logic [NUM_CH-1:0]   vld_p0, vld_p1;
  logic [DATA_W-1:0]   resp_data_p0 [NUM_CH];
  logic [DATA_W-1:0]   resp_data_p1 [NUM_CH];
  logic                oob_err_q, oob_err_d;
  logic [15:0]         drop_q, drop_d;

  assign busy = (state_q == SWEEP) || clear;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign idx[c]     = req_bits_index[c*IDX_W +: IDX_W];
    assign addr[c]    = idx[c][ADDR_W-1:0];
    assign wr_data[c] = req_bits_data[c*DATA_W +: DATA_W];
    assign oob[c]     = 32'(idx[c]) >= DEPTH_U;
    assign wr_req[c]  = req_valid[c] && req_bits_update[c] && !oob[c] && !busy;
    assign wr_addr_flat[c*ADDR_W +: ADDR_W] = addr[c];
    assign resp_bits_data[c*DATA_W +: DATA_W] = resp_data_p1[c];
  end

  extern_reg_wr_arb #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W)
  ) u_wr_arb (
    .wr_req  (wr_req),
    .wr_addr (wr_addr_flat),
    .wr_en   (wr_en)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SWEEP;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (clear) begin
      state_d = SWEEP;
      ptr_d   = '0;
    end else if (state_q == SWEEP) begin
      if (ptr_q == ADDR_W'(DEPTH - 1)) begin
        state_d = READY;
        ptr_d   = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  always_comb begin
    sweep_we    = (state_q == SWEEP);
    init_done_d = (state_d == READY);
  end

  assign init_done = init_done_q;

  // Stage 0: array read (pre-write value), range check, drop accounting
  always_comb begin
    logic [2:0] nreq;
    nreq      = '0;
    vld_p0    = req_valid;
    oob_err_d = oob_err_q;
    drop_d    = drop_q;
    for (int c = 0; c < NUM_CH; c++) begin
      resp_data_p0[c] = resp_data_p1[c];
      if (req_valid[c]) begin
        nreq = nreq + 3'd1;
        if (oob[c]) oob_err_d = 1'b1;
        if (busy)        resp_data_p0[c] = RESET_VAL;
        else if (oob[c]) resp_data_p0[c] = '0;
        else             resp_data_p0[c] = mem_q[addr[c]];
      end
    end
    if (busy) drop_d = sat_add16(drop_q, nreq);
  end

  // Stage 1: registered response, sticky status
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1    <= '0;
      oob_err_q <= 1'b0;
      drop_q    <= '0;
      for (int c = 0; c < NUM_CH; c++) resp_data_p1[c] <= '0;
    end else begin
      vld_p1    <= vld_p0;
      oob_err_q <= oob_err_d;
      drop_q    <= drop_d;
      for (int c = 0; c < NUM_CH; c++) resp_data_p1[c] <= resp_data_p0[c];
    end
  end

  assign resp_valid    = vld_p1;
  assign oob_err       = oob_err_q;
  assign init_drop_cnt = drop_q;

  // Array is initialised by the sweep rather than by reset
  always_ff @(posedge clock) begin
    if (sweep_we) mem_q[ptr_q] <= RESET_VAL;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_en[c]) mem_q[addr[c]] <= wr_data[c];
    end
  end

endmodule

// File: tb/tb_extern_reg_array.sv
// Directed plus randomized bench for extern_reg_array against a per-cycle reference model.
module tb_extern_reg_array;

  localparam int NCH   = 2;
  localparam int DEP   = 1024;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [31:0] req_bits_index;
  logic [1:0]  req_bits_update;
  logic [15:0] req_bits_data;
  logic [1:0]  resp_valid;
  logic [15:0] resp_bits_data;
  logic        clear;
  logic        init_done;
  logic        oob_err;
  logic [15:0] init_drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem_m [DEP];
  int         sweep_left;
  int         drop_m;
  bit         oob_m;
  logic [1:0] exp_vld;
  logic [7:0] exp_data [NCH];

  extern_reg_array dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_bits_index (req_bits_index),
    .req_bits_update(req_bits_update),
    .req_bits_data  (req_bits_data),
    .resp_valid     (resp_valid),
    .resp_bits_data (resp_bits_data),
    .clear          (clear),
    .init_done      (init_done),
    .oob_err        (oob_err),
    .init_drop_cnt  (init_drop_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEP; i++) mem_m[i] = 8'h00;
    sweep_left = DEP;
    drop_m     = 0;
    oob_m      = 1'b0;
    exp_vld    = '0;
  endtask

  // Apply the behavioural rules to the inputs presented this cycle.
  task automatic model_step();
    bit busy;
    int ix [NCH];
    busy = (sweep_left > 0) || clear;
    for (int c = 0; c < NCH; c++) begin
      ix[c] = int'(req_bits_index[c*16 +: 16]);
      if (req_valid[c]) begin
        if (ix[c] >= DEP) oob_m = 1'b1;
        if (busy || ix[c] >= DEP) exp_data[c] = 8'h00;
        else                      exp_data[c] = mem_m[ix[c]];
      end
    end
    exp_vld = req_valid;
    if (busy) begin
      drop_m = drop_m + $countones(req_valid);
      if (drop_m > 65535) drop_m = 65535;
    end else begin
      for (int c = NCH - 1; c >= 0; c--) begin
        if (req_valid[c] && req_bits_update[c] && ix[c] < DEP)
          mem_m[ix[c]] = req_bits_data[c*8 +: 8];
      end
    end
    if (clear) begin
      sweep_left = DEP;
      for (int i = 0; i < DEP; i++) mem_m[i] = 8'h00;
    end else if (sweep_left > 0) begin
      sweep_left--;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    chk("resp_valid", 32'(resp_valid), 32'(exp_vld));
    for (int c = 0; c < NCH; c++) begin
      if (exp_vld[c]) chk($sformatf("resp_data%0d", c), 32'(resp_bits_data[c*8 +: 8]), 32'(exp_data[c]));
    end
    chk("init_done", 32'(init_done), 32'(sweep_left == 0));
    chk("oob_err", 32'(oob_err), 32'(oob_m));
    chk("init_drop_cnt", 32'(init_drop_cnt), 32'(drop_m));
    req_valid       = '0;
    req_bits_update = '0;
    clear           = 1'b0;
  endtask

  task automatic set_req(input int c, input int idx, input bit upd, input logic [7:0] d);
    req_valid[c]             = 1'b1;
    req_bits_index[c*16 +: 16] = idx[15:0];
    req_bits_update[c]       = upd;
    req_bits_data[c*8 +: 8]  = d;
  endtask

  task automatic wait_init(input int start, output int cycles);
    cycles = start;
    while (!init_done && cycles < 2000) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    int cnt;
    req_valid       = '0;
    req_bits_index  = '0;
    req_bits_update = '0;
    req_bits_data   = '0;
    clear           = 1'b0;
    reset_n         = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", 32'(resp_bits_data), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_oob_err", 32'(oob_err), 32'd0);
    chk("rst_drop_cnt", 32'(init_drop_cnt), 32'd0);

    reset_n = 1'b1;
    model_reset();
    wait_init(0, cnt);
    chk("init_latency", 32'(cnt), 32'd1024);

    set_req(0, 5, 1'b0, 8'h00); tick();
    chk("rd_idx5", 32'(resp_bits_data[7:0]), 32'h00);

    set_req(0, 7, 1'b1, 8'h3C); tick();
    chk("wr_idx7_resp", 32'(resp_bits_data[7:0]), 32'h00);
    set_req(0, 7, 1'b0, 8'h00); tick();
    chk("rd_idx7", 32'(resp_bits_data[7:0]), 32'h3C);

    set_req(0, 9, 1'b1, 8'h11); set_req(1, 9, 1'b1, 8'h22); tick();
    chk("conflict_resp", 32'(resp_bits_data), 32'h0000);
    set_req(1, 9, 1'b0, 8'h00); tick();
    chk("conflict_winner", 32'(resp_bits_data[15:8]), 32'h11);

    set_req(1, 1024, 1'b1, 8'h55); tick();
    chk("oob_valid", 32'(resp_valid), 32'd2);
    chk("oob_data", 32'(resp_bits_data[15:8]), 32'h00);
    chk("oob_set", 32'(oob_err), 32'd1);
    repeat (100) tick();
    chk("oob_sticky", 32'(oob_err), 32'd1);
    set_req(0, 0, 1'b0, 8'h00); tick();
    chk("rd_idx0", 32'(resp_bits_data[7:0]), 32'h00);

    set_req(0, 3, 1'b1, 8'hAA); tick();
    clear = 1'b1; tick();
    chk("clear_drops_done", 32'(init_done), 32'd0);
    for (int k = 0; k < 3; k++) begin
      set_req(0, k + 3, 1'b1, 8'($urandom));
      set_req(1, 3, 1'b1, 8'($urandom));
      tick();
      chk("sweep_resp", 32'(resp_bits_data), 32'h0000);
    end
    chk("drop_cnt6", 32'(init_drop_cnt), 32'd6);
    wait_init(3, cnt);
    chk("clear_latency", 32'(cnt), 32'd1024);
    set_req(0, 3, 1'b0, 8'h00); tick();
    chk("rd_idx3_cleared", 32'(resp_bits_data[7:0]), 32'h00);

    for (int k = 0; k < 400; k++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 9) < 7) begin
          if ($urandom_range(0, 19) == 0) set_req(c, 1024 + int'($urandom_range(0, 64511)), 1'($urandom), 8'($urandom));
          else set_req(c, int'($urandom_range(0, 15)), 1'($urandom), 8'($urandom));
        end
      end
      tick();
    end

    clear = 1'b1; tick();
    repeat (10) begin
      set_req(0, int'($urandom_range(0, 15)), 1'b1, 8'($urandom));
      tick();
    end
    clear = 1'b1; tick();
    wait_init(0, cnt);
    chk("restart_latency", 32'(cnt), 32'd1024);

    set_req(0, 2, 1'b0, 8'h00); tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_init_done", 32'(init_done), 32'd0);
    chk("midrst_drop_cnt", 32'(init_drop_cnt), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
    wait_init(0, cnt);
    chk("midrst_latency", 32'(cnt), 32'd1024);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
